// File: rtl/snn_inference_ctrl.sv
// Sequences one spiking-network inference: clear, run N timesteps, scan the class counters, present the winner.
// Winner is the lowest index holding the maximum count; tie_o flags that a later class matched it.
module snn_inference_ctrl #(
  parameter int NUM_CLASSES = 10,
  parameter int COUNT_W     = 8,
  parameter int STEP_W      = 8,
  parameter int CLASS_W     = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [STEP_W-1:0]  num_steps_i,
  output logic               busy_o,
  output logic               net_clear_o,
  output logic               net_en_o,
  output logic [STEP_W-1:0]  step_o,
  output logic [CLASS_W-1:0] count_sel_o,
  input  logic [COUNT_W-1:0] count_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [CLASS_W-1:0] result_class_o,
  output logic [COUNT_W-1:0] result_count_o,
  output logic               tie_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SCAN,
    S_DONE
  } state_t;

  localparam logic [CLASS_W-1:0] LAST_SEL = CLASS_W'(NUM_CLASSES - 1);

  state_t               state_q;
  logic [STEP_W-1:0]    n_q;
  logic [STEP_W-1:0]    step_q;
  logic [CLASS_W-1:0]   sel_q;
  logic [CLASS_W-1:0]   idx_q;
  logic [COUNT_W-1:0]   max_q;
  logic                 tie_q;
  logic                 busy_q;
  logic                 net_clear_q;
  logic                 net_en_q;
  logic                 valid_q;
  logic [CLASS_W-1:0]   res_class_q;
  logic [COUNT_W-1:0]   res_count_q;
  logic                 res_tie_q;

  logic [COUNT_W-1:0]   max_d;
  logic [CLASS_W-1:0]   idx_d;
  logic                 tie_d;

  // Running arg-max over the counter currently selected by sel_q.
  always_comb begin
    max_d = max_q;
    idx_d = idx_q;
    tie_d = tie_q;
    if (sel_q == '0) begin
      max_d = count_i;
      idx_d = '0;
      tie_d = 1'b0;
    end else if (count_i > max_q) begin
      max_d = count_i;
      idx_d = sel_q;
      tie_d = 1'b0;
    end else if (count_i == max_q) begin
      tie_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      step_q      <= '0;
      sel_q       <= '0;
      idx_q       <= '0;
      max_q       <= '0;
      tie_q       <= 1'b0;
      busy_q      <= 1'b0;
      net_clear_q <= 1'b0;
      net_en_q    <= 1'b0;
      valid_q     <= 1'b0;
      res_class_q <= '0;
      res_count_q <= '0;
      res_tie_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q     <= S_CLEAR;
            n_q         <= num_steps_i;
            busy_q      <= 1'b1;
            net_clear_q <= 1'b1;
          end
        end
        S_CLEAR: begin
          net_clear_q <= 1'b0;
          step_q      <= '0;
          sel_q       <= '0;
          if (n_q != '0) begin
            state_q  <= S_RUN;
            net_en_q <= 1'b1;
          end else begin
            state_q <= S_SCAN;
          end
        end
        S_RUN: begin
          // Compare against N-1 so the full-scale count never needs a wider step register.
          if (step_q == n_q - STEP_W'(1)) begin
            state_q  <= S_SCAN;
            net_en_q <= 1'b0;
            step_q   <= '0;
            sel_q    <= '0;
          end else begin
            step_q <= step_q + STEP_W'(1);
          end
        end
        S_SCAN: begin
          max_q <= max_d;
          idx_q <= idx_d;
          tie_q <= tie_d;
          if (sel_q == LAST_SEL) begin
            state_q     <= S_DONE;
            sel_q       <= '0;
            valid_q     <= 1'b1;
            res_class_q <= idx_d;
            res_count_q <= max_d;
            res_tie_q   <= tie_d;
          end else begin
            sel_q <= sel_q + CLASS_W'(1);
          end
        end
        S_DONE: begin
          if (result_ready_i) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign net_clear_o    = net_clear_q;
  assign net_en_o       = net_en_q;
  assign step_o         = step_q;
  assign count_sel_o    = sel_q;
  assign result_valid_o = valid_q;
  assign result_class_o = res_class_q;
  assign result_count_o = res_count_q;
  assign tie_o          = res_tie_q;

  a_clear_en_exclusive: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(net_en_o && net_clear_o));

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// Bench for snn_inference_ctrl: a phase-by-cycle reference model plus directed and random inferences.
`timescale 1ns/1ps
module tb_snn_inference_ctrl;
  localparam int NCLS = 10;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       start_i;
  logic [7:0] num_steps_i;
  logic       busy_o, net_clear_o, net_en_o;
  logic [7:0] step_o;
  logic [3:0] count_sel_o;
  logic [7:0] count_i;
  logic       result_valid_o, result_ready_i;
  logic [3:0] result_class_o;
  logic [7:0] result_count_o;
  logic       tie_o;

  logic [7:0] counts [NCLS];

  int total = 0;
  int bad = 0;
  int en_cnt = 0, clr_cnt = 0, hs_cnt = 0, idle_cnt = 0;

  always #5 clk_i = ~clk_i;

  snn_inference_ctrl #(.NUM_CLASSES(NCLS), .COUNT_W(8), .STEP_W(8), .CLASS_W(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .num_steps_i(num_steps_i),
    .busy_o(busy_o), .net_clear_o(net_clear_o), .net_en_o(net_en_o), .step_o(step_o),
    .count_sel_o(count_sel_o), .count_i(count_i), .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i), .result_class_o(result_class_o),
    .result_count_o(result_count_o), .tie_o(tie_o)
  );

  // Readout emulation: the selected counter, combinationally.
  assign count_i = (int'(count_sel_o) < NCLS) ? counts[count_sel_o] : 8'd0;

  // Reference model: mst=1 while an inference is in flight, mm = edges since acceptance (1 right after it).
  int mst = 0, mn = 0, mm = 0;
  int r_cls = 0, r_cnt = 0, r_tie = 0;

  always @(posedge clk_i or negedge rst_ni) begin : model
    int best, hits;
    if (!rst_ni) begin
      mst = 0; mn = 0; mm = 0; r_cls = 0; r_cnt = 0; r_tie = 0;
    end else if (mst == 0) begin
      if (start_i) begin
        mst = 1; mn = int'(num_steps_i); mm = 1;
      end
    end else if (mm >= mn + 12) begin
      if (result_ready_i) mst = 0;
    end else begin
      if (mm == mn + 11) begin
        best = 0;
        for (int i = 1; i < NCLS; i++) if (counts[i] > counts[best]) best = i;
        hits = 0;
        for (int i = 0; i < NCLS; i++) if (counts[i] == counts[best]) hits++;
        r_cls = best; r_cnt = int'(counts[best]); r_tie = (hits > 1) ? 1 : 0;
      end
      mm++;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int act_run, e_en, e_sel_on;
    act_run  = (mst == 1) ? 1 : 0;
    e_en     = (act_run == 1 && mm >= 2 && mm <= mn + 1) ? 1 : 0;
    e_sel_on = (act_run == 1 && mm >= mn + 2 && mm <= mn + 11) ? 1 : 0;
    check("busy", int'(busy_o), act_run);
    check("net_clear", int'(net_clear_o), (act_run == 1 && mm == 1) ? 1 : 0);
    check("net_en", int'(net_en_o), e_en);
    check("step", int'(step_o), (e_en == 1) ? mm - 2 : 0);
    check("count_sel", int'(count_sel_o), (e_sel_on == 1) ? mm - mn - 2 : 0);
    check("valid", int'(result_valid_o), (act_run == 1 && mm >= mn + 12) ? 1 : 0);
    check("res_class", int'(result_class_o), r_cls);
    check("res_count", int'(result_count_o), r_cnt);
    check("tie", int'(tie_o), r_tie);
  endtask

  // Every cycle: compare at the falling edge, then step to just after the next rising edge.
  task automatic tick();
    @(negedge clk_i);
    if (rst_ni) begin
      compare_all();
      if (net_en_o) en_cnt++;
      if (net_clear_o) clr_cnt++;
      if (result_valid_o && result_ready_i) hs_cnt++;
      if (!busy_o) idle_cnt++;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic infer(input int n, input int dly, input bit noisy, output int lat);
    int en0, clr0;
    en0 = en_cnt; clr0 = clr_cnt;
    num_steps_i = 8'(n);
    start_i = 1'b1;
    result_ready_i = (dly == 0);
    tick();
    start_i = 1'b0;
    lat = 0;
    while (!result_valid_o && lat < n + 40) begin
      if (noisy) begin
        start_i = 1'($urandom_range(0, 1));
        num_steps_i = 8'($urandom);
      end
      tick();
      lat++;
    end
    start_i = 1'b0;
    check("valid_seen", int'(result_valid_o), 1);
    for (int i = 1; i < dly; i++) tick();
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    check("en_cycles", en_cnt - en0, n);
    check("clear_cycles", clr_cnt - clr0, 1);
  endtask

  initial begin
    int lat, k, hs0, idle0;
    rst_ni = 1'b0; start_i = 1'b0; num_steps_i = '0; result_ready_i = 1'b0;
    for (int i = 0; i < NCLS; i++) counts[i] = 8'd0;
    #1;
    check("rst_busy", int'(busy_o), 0);
    check("rst_valid", int'(result_valid_o), 0);
    check("rst_class", int'(result_class_o), 0);
    check("rst_clear_en", int'(net_clear_o) + int'(net_en_o), 0);
    @(posedge clk_i); #1;
    tick();
    rst_ni = 1'b1;
    tick();

    // 1: N=4, tie between classes 1 and 3
    counts = '{8'd3, 8'd7, 8'd2, 8'd7, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    infer(4, 2, 1'b0, lat);
    check("t1_latency", lat, 15);
    check("t1_class", int'(result_class_o), 1);
    check("t1_count", int'(result_count_o), 7);
    check("t1_tie", int'(tie_o), 1);

    // 2: N=0, cleared counters
    for (int i = 0; i < NCLS; i++) counts[i] = 8'd0;
    infer(0, 1, 1'b0, lat);
    check("t2_latency", lat, 11);
    check("t2_class", int'(result_class_o), 0);
    check("t2_count", int'(result_count_o), 0);
    check("t2_tie", int'(tie_o), 1);

    // 3: unique max at class 9, consumer stalls 5 cycles
    for (int i = 0; i < NCLS; i++) counts[i] = 8'(i * 10);
    counts[9] = 8'd200;
    infer(3, 6, 1'b0, lat);
    check("t3_class", int'(result_class_o), 9);
    check("t3_count", int'(result_count_o), 200);
    check("t3_tie", int'(tie_o), 0);
    check("t3_idle_busy", int'(busy_o), 0);
    check("t3_idle_valid", int'(result_valid_o), 0);

    // 4a: start noise during RUN/SCAN is ignored
    hs0 = hs_cnt;
    infer(5, 1, 1'b1, lat);
    check("t4_latency", lat, 16);
    tick(); tick();
    check("t4_one_result", hs_cnt - hs0, 1);

    // 4b: start held high, ready held high -> back-to-back with one idle cycle between
    num_steps_i = 8'd2; start_i = 1'b1; result_ready_i = 1'b1;
    tick();
    hs0 = hs_cnt; idle0 = idle_cnt;
    for (int i = 0; i < 44; i++) tick();
    start_i = 1'b0;
    check("t4_b2b_results", hs_cnt - hs0, 3);
    check("t4_b2b_idle", idle_cnt - idle0, 2);
    tick();
    result_ready_i = 1'b0;
    tick();

    // 5: async reset mid-RUN
    num_steps_i = 8'd6; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    k = 0;
    while (step_o != 8'd2 && k < 10) begin tick(); k++; end
    check("t5_reached_step2", int'(step_o), 2);
    #2 rst_ni = 1'b0;
    #1;
    check("t5_busy", int'(busy_o), 0);
    check("t5_en", int'(net_en_o), 0);
    check("t5_clear", int'(net_clear_o), 0);
    check("t5_step", int'(step_o), 0);
    check("t5_valid", int'(result_valid_o), 0);
    check("t5_class", int'(result_class_o), 0);
    check("t5_count", int'(result_count_o), 0);
    check("t5_tie", int'(tie_o), 0);
    tick();
    rst_ni = 1'b1;
    tick();
    counts = '{8'd1, 8'd2, 8'd9, 8'd4, 8'd9, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0};
    infer(3, 1, 1'b0, lat);
    check("t5_after_class", int'(result_class_o), 2);
    check("t5_after_tie", int'(tie_o), 1);

    // 6: full-scale step count
    for (int i = 0; i < NCLS; i++) counts[i] = 8'd254;
    counts[4] = 8'd255;
    infer(255, 1, 1'b0, lat);
    check("t6_latency", lat, 266);
    check("t6_class", int'(result_class_o), 4);
    check("t6_count", int'(result_count_o), 255);
    check("t6_tie", int'(tie_o), 0);

    // Random inferences against the model
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < NCLS; i++)
        counts[i] = (it % 3 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      infer($urandom_range(0, 12), $urandom_range(0, 3), 1'($urandom_range(0, 1)), lat);
      if ($urandom_range(0, 1) == 1) tick();
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
